// File: rtl/fre_meter_bcd.sv
// fre_meter_bcd: gated BCD frequency meter.
// Rising edges of the asynchronous `signal` input are counted in a chain of
// DIGITS decimal decades for exactly GATE_CYCLES clocks. The count is then
// latched to QO together with a sticky overflow flag.
//
// Output handshake: `valid` is a one-cycle strobe with no back-pressure (no
// ready). QO/ovf change only in the cycle where valid=1 (or on reset) and hold
// until the next strobe. `start` is a single-cycle request that is accepted
// only while busy=0; requests made while busy=1 are dropped, not queued.
module fre_meter_bcd #(
  parameter int DIGITS      = 4,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal,
  input  logic                  cont,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   QO,
  output logic                  valid,
  output logic                  ovf,
  output logic                  busy
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  // Gate counter value during the last GATE cycle (counter starts at 0 in GATE cycle 1).
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    GATE = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [GW-1:0]               gate_cnt_q;
  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        sync_d_q;
  logic                        rise;
  logic                        count_en;
  logic [DIGITS-1:0][3:0]      dec_q;
  logic [DIGITS-1:0]           inc_en;
  logic                        sat_hit;
  logic                        ovf_sticky_q;

  // Synchroniser plus one edge register on the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], signal};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~sync_d_q;
  // Edges outside the gate window (IDLE, CLR, LOAD) are dropped here.
  assign count_en = rise & (state_q == GATE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; cont is looked at only in IDLE and LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cont || start) begin
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = GATE;
      end
      GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = cont ? CLR : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // Gate length counter: cleared in CLR, advances once per GATE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt_q <= '0;
    end else if (state_q == CLR) begin
      gate_cnt_q <= '0;
    end else if (state_q == GATE) begin
      gate_cnt_q <= gate_cnt_q + GW'(1);
    end
  end

  // Ripple enables for the decade chain: digit k steps when every lower digit is 9.
  always_comb begin
    logic c;
    c      = count_en;
    inc_en = '0;
    for (int k = 0; k < DIGITS; k++) begin
      inc_en[k] = c;
      c         = c & (dec_q[k] == 4'd9);
    end
    // Carry out of the top digit means the chain is already all nines.
    sat_hit = c;
  end

  // Decade chain with saturation at all nines and a sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else if (state_q == CLR) begin
      dec_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else if (sat_hit) begin
      // Hold all nines; further edges in this gate only keep the flag set.
      ovf_sticky_q <= 1'b1;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (inc_en[k]) begin
          dec_q[k] <= (dec_q[k] == 4'd9) ? 4'd0 : dec_q[k] + 4'd1;
        end
      end
    end
  end

  // Result registers: captured in LOAD, visible with the valid strobe one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      QO    <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= (state_q == LOAD);
      if (state_q == LOAD) begin
        QO  <= dec_q;
        ovf <= ovf_sticky_q;
      end
    end
  end

endmodule

// File: tb/tb_fre_meter_bcd.sv
// Bench for fre_meter_bcd: three instances driven by independent stimulus
// threads, each with a scoreboard queue of {ovf, QO} results checked on valid.
module tb_fre_meter_bcd;

  logic clk;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Instance a: DIGITS=4, GATE_CYCLES=1000
  logic        rst_a, sig_a, cont_a, start_a;
  logic [15:0] qo_a;
  logic        valid_a, ovf_a, busy_a;
  int          half_a = 0;
  int          vcnt_a = 0;
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_a;

  // Instance b: DIGITS=2, GATE_CYCLES=1000
  logic        rst_b, sig_b, cont_b, start_b;
  logic [7:0]  qo_b;
  logic        valid_b, ovf_b, busy_b;
  int          half_b = 0;
  logic [8:0]  exp_q_b[$];
  logic [8:0]  exp_b;

  // Instance c: DIGITS=4, GATE_CYCLES=9998
  logic        rst_c, sig_c, cont_c, start_c;
  logic [15:0] qo_c;
  logic        valid_c, ovf_c, busy_c;
  int          half_c = 0;
  logic [16:0] exp_q_c[$];
  logic [16:0] exp_c;

  bit done_b = 0;
  bit done_c = 0;

  fre_meter_bcd #(.DIGITS(4), .GATE_CYCLES(1000), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst_a), .signal(sig_a), .cont(cont_a), .start(start_a),
    .QO(qo_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
  );

  fre_meter_bcd #(.DIGITS(2), .GATE_CYCLES(1000), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst_b), .signal(sig_b), .cont(cont_b), .start(start_b),
    .QO(qo_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
  );

  fre_meter_bcd #(.DIGITS(4), .GATE_CYCLES(9998), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst_c), .signal(sig_c), .cont(cont_c), .start(start_c),
    .QO(qo_c), .valid(valid_c), .ovf(ovf_c), .busy(busy_c)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Input generators: toggle every half_x clocks, held low when half_x == 0
  initial begin
    int cnt = 0;
    sig_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (half_a == 0) begin sig_a = 1'b0; cnt = 0; end
      else begin cnt++; if (cnt >= half_a) begin cnt = 0; sig_a = ~sig_a; end end
    end
  end

  initial begin
    int cnt = 0;
    sig_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (half_b == 0) begin sig_b = 1'b0; cnt = 0; end
      else begin cnt++; if (cnt >= half_b) begin cnt = 0; sig_b = ~sig_b; end end
    end
  end

  initial begin
    int cnt = 0;
    sig_c = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (half_c == 0) begin sig_c = 1'b0; cnt = 0; end
      else begin cnt++; if (cnt >= half_c) begin cnt = 0; sig_c = ~sig_c; end end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for valid on instance a; returns cycle and busy at that sample.
  task automatic wait_valid_a(input int budget, input string name, output int at, output logic bsy);
    int n = 0;
    @(negedge clk);
    while (!valid_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(valid_a), 1);
    at  = cyc;
    bsy = busy_a;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitors: pop and compare whenever a valid strobe appears
  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a++;
      chk("a_sb_pending", 32'(exp_q_a.size() != 0), 1);
      if (exp_q_a.size() != 0) begin
        exp_a = exp_q_a.pop_front();
        chk("a_result", 32'({ovf_a, qo_a}), 32'(exp_a));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      chk("b_sb_pending", 32'(exp_q_b.size() != 0), 1);
      if (exp_q_b.size() != 0) begin
        exp_b = exp_q_b.pop_front();
        chk("b_result", 32'({ovf_b, qo_b}), 32'(exp_b));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_c) begin
      chk("c_sb_pending", 32'(exp_q_c.size() != 0), 1);
      if (exp_q_c.size() != 0) begin
        exp_c = exp_q_c.pop_front();
        chk("c_result", 32'({ovf_c, qo_c}), 32'(exp_c));
      end
    end
  end

  // Instance b: overflow gate then an empty gate
  initial begin
    int n;
    rst_b = 1'b1; cont_b = 1'b0; start_b = 1'b0;
    tick(3);
    rst_b = 1'b0;
    half_b = 2;                          // period 4 -> 250 edges per gate
    tick(20);
    exp_q_b.push_back({1'b1, 8'h99});
    start_b = 1'b1; tick(1); start_b = 1'b0;
    for (n = 0; n < 1100 && !valid_b; n++) @(negedge clk);
    chk("b_valid_ovf_timeout", 32'(valid_b), 1);
    tick(1);
    half_b = 0;                          // held low
    tick(20);
    exp_q_b.push_back({1'b0, 8'h00});
    start_b = 1'b1; tick(1); start_b = 1'b0;
    for (n = 0; n < 1100 && !valid_b; n++) @(negedge clk);
    chk("b_valid_low_timeout", 32'(valid_b), 1);
    tick(1);
    done_b = 1;
  end

  // Instance c: max-rate input over 9998 cycles -> 4999 edges
  initial begin
    int n;
    rst_c = 1'b1; cont_c = 1'b0; start_c = 1'b0;
    tick(3);
    rst_c = 1'b0;
    half_c = 1;
    tick(20);
    exp_q_c.push_back({1'b0, 16'h4999});
    start_c = 1'b1; tick(1); start_c = 1'b0;
    for (n = 0; n < 10100 && !valid_c; n++) @(negedge clk);
    chk("c_valid_timeout", 32'(valid_c), 1);
    tick(1);
    done_c = 1;
  end

  // Instance a: main sequence, then summary
  initial begin
    int   t, c1, c2, c3, n;
    logic bsy;
    rst_a = 1'b1; cont_a = 1'b0; start_a = 1'b0;
    tick(3);
    @(negedge clk);
    chk("a_rst_qo", 32'(qo_a), 0);
    chk("a_rst_valid", 32'(valid_a), 0);
    chk("a_rst_ovf", 32'(ovf_a), 0);
    chk("a_rst_busy", 32'(busy_a), 0);
    @(posedge clk); #1;
    rst_a = 1'b0;

    // Continuous mode, period-10 input; cont dropped mid third gate
    half_a = 5;
    tick(20);
    repeat (3) exp_q_a.push_back({1'b0, 16'h0100});
    cont_a = 1'b1;
    t = cyc;
    wait_valid_a(1100, "a_cont_v1_timeout", c1, bsy);
    chk("a_cont_first_latency", c1 - t, 1003);
    chk("a_cont_busy_v1", 32'(bsy), 1);
    wait_valid_a(1100, "a_cont_v2_timeout", c2, bsy);
    chk("a_cont_period_12", c2 - c1, 1002);
    tick(500);
    cont_a = 1'b0;
    wait_valid_a(1100, "a_cont_v3_timeout", c3, bsy);
    chk("a_cont_period_23", c3 - c2, 1002);
    chk("a_cont_busy_v3", 32'(bsy), 0);
    tick(1100);
    chk("a_cont_busy_idle", 32'(busy_a), 0);
    chk("a_cont_vcount", vcnt_a, 3);

    // Single-shot, period-4 input, second start mid-gate ignored
    half_a = 2;
    tick(20);
    exp_q_a.push_back({1'b0, 16'h0250});
    start_a = 1'b1;
    t = cyc;
    tick(1);
    start_a = 1'b0;
    @(negedge clk);
    chk("a_ss_busy_clr", 32'(busy_a), 1);
    tick(500);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_valid_a(700, "a_ss_valid_timeout", c1, bsy);
    chk("a_ss_latency", c1 - t, 1003);
    chk("a_ss_busy_at_valid", 32'(bsy), 0);
    tick(1100);
    @(negedge clk);
    chk("a_ss_qo_held", 32'(qo_a), 32'h0250);
    chk("a_ss_busy_idle", 32'(busy_a), 0);
    chk("a_ss_vcount", vcnt_a, 4);

    // Reset mid-gate, then continuous restart with signal held low
    @(posedge clk); #1;
    half_a = 5;
    tick(20);
    cont_a = 1'b1;
    tick(502);
    rst_a  = 1'b1;
    half_a = 0;
    tick(1);
    @(negedge clk);
    chk("a_midrst_qo", 32'(qo_a), 0);
    chk("a_midrst_valid", 32'(valid_a), 0);
    chk("a_midrst_busy", 32'(busy_a), 0);
    chk("a_midrst_ovf", 32'(ovf_a), 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    t = cyc;
    exp_q_a.push_back({1'b0, 16'h0000});
    tick(500);
    cont_a = 1'b0;
    wait_valid_a(700, "a_rel_valid_timeout", c1, bsy);
    chk("a_rel_latency", c1 - t, 1003);
    tick(1100);
    chk("a_rel_vcount", vcnt_a, 5);
    chk("a_rel_busy_idle", 32'(busy_a), 0);

    // Wait for the other instances, bounded
    for (n = 0; n < 20000 && !(done_b && done_c); n++) @(posedge clk);
    chk("b_done", 32'(done_b), 1);
    chk("c_done", 32'(done_c), 1);
    tick(5);
    chk("a_queue_drained", exp_q_a.size(), 0);
    chk("b_queue_drained", exp_q_b.size(), 0);
    chk("c_queue_drained", exp_q_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
